up_down_counter_mod: RTL and testbench
======================================

Name: up_down_counter_mod

Overview:
Parametrised synchronous up/down counter. It generalises the team's fixed 3-bit up/down counter to any width and any modulus, and adds:
- count enable
- parallel load
- wrap or saturate mode
- terminal-count flag
- registered wrap pulse

It is used as a general sequencing and timing counter in the lab designs. The counter is a single clocked register with no internal sub-state.

Parameters:
WIDTH, 4, counter register width in bits (2..16)
MODULUS, 16, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low reset
EN  input  1  count enable; counts one step per CLK edge while high
M  input  1  direction: 1 = up, 0 = down
LOAD  input  1  synchronous parallel load strobe
D  input  WIDTH  load value
Q  output  WIDTH  current count
TC  output  1  terminal count, combinational from Q and M
WRAP  output  1  registered one-cycle pulse on a wrap or saturation event

Behaviour:
- Reset: CLR low forces Q=0 and WRAP=0 immediately, independent of CLK.
  - Outputs hold while CLR is low.
  - The first count can occur on the first rising CLK edge after CLR is released.
  - CLR asserted mid-count aborts the count with no glitch pulse on WRAP.
- Priority on each rising edge (CLR high): LOAD > EN > hold.
- LOAD=1:
  - Q <= D if D <= MODULUS-1; otherwise Q <= MODULUS-1 (clamp).
  - WRAP <= 0.
  - EN and M are ignored that cycle.
- LOAD=0, EN=1, M=1 (up):
  - If Q < MODULUS-1: Q <= Q+1.
  - If Q == MODULUS-1: Q <= 0 when SATURATE=0, or holds when SATURATE=1. In either case WRAP <= 1.
- LOAD=0, EN=1, M=0 (down):
  - If Q > 0: Q <= Q-1.
  - If Q == 0: Q <= MODULUS-1 when SATURATE=0, or holds when SATURATE=1. In either case WRAP <= 1.
- LOAD=0, EN=0: Q holds; WRAP <= 0.
- WRAP timing:
  - High for exactly the one cycle following the boundary edge.
  - Stays high on consecutive cycles only if the boundary event repeats; this happens in saturate mode while EN stays high at the end value.
- TC = (M==1 && Q==MODULUS-1) || (M==0 && Q==0).
  - TC is combinational, so it changes immediately with M.
  - Not gated by EN, so a cascaded stage can use TC & EN as its own enable.
- Direction change: M is sampled at the edge. Toggling M between edges has no effect on Q until the next enabled edge.
- Arithmetic:
  - Performed in WIDTH+1 bits internally.
  - Q never takes a value >= MODULUS, including when MODULUS < 2**WIDTH.
- Implementation:
  - Flip-flop based register, dataflow next-state logic.
  - No latches; all outputs defined on every path.

Test Plan:
1. WIDTH=4, MODULUS=16, SATURATE=0. Release CLR, EN=1, M=1, 17 edges -> Q steps 1..15, 0, 1. WRAP=1 only in the cycle Q=0. TC=1 while Q=15.
2. MODULUS=10, down count. LOAD=1 with D=2, then EN=1 and M=0 for 4 edges -> Q=2,1,0,9,8. WRAP pulses once, after the 0->9 step.
3. SATURATE=1, MODULUS=10. LOAD D=8, EN=1, M=1, 4 edges -> Q=9,9,9,9. WRAP is high for 3 consecutive cycles, then drops when EN=0.
4. MODULUS=10. LOAD D=13 -> Q=9, TC=1. Assert LOAD and EN in the same edge with D=4 -> Q=4 (load wins), WRAP=0.
5. While counting at Q=6, pull CLR low between CLK edges -> Q=0 and WRAP=0 immediately. Q stays 0 across 3 edges while CLR is low. After release, the first edge gives Q=1.
6. At Q=0 with M=1 (TC=0), flip M to 0 mid-cycle -> TC=1 immediately, Q unchanged. The next enabled edge gives Q=MODULUS-1.

Source files
------------

// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with enable, load, wrap/saturate,
// terminal count and a registered boundary pulse.
module up_down_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             M,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    localparam int W1 = WIDTH + 1;

    // Range bound, in both the extended and the register width.
    localparam logic [WIDTH:0]   MAX_X = W1'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   d_x;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic             nxt_wrap;

    // Bound tests are done one bit wider so a modulus of 2**WIDTH
    // and out-of-range load values compare correctly.
    assign q_x    = {1'b0, Q};
    assign d_x    = {1'b0, D};
    assign at_top = (q_x == MAX_X);
    assign at_bot = (q_x == '0);

    // Step values, including end-of-range behaviour.
    assign inc = at_top ? (SATURATE ? Q : '0) : Q + 1'b1;
    assign dec = at_bot ? (SATURATE ? Q : MAX_Q) : Q - 1'b1;

    // Loads never put Q outside the count range.
    assign load_val = (d_x > MAX_X) ? MAX_Q : D;

    // Terminal count follows the live direction input.
    assign TC = M ? at_top : at_bot;

    // Next count and boundary pulse: load beats enable beats hold.
    always_comb begin
        nxt      = Q;
        nxt_wrap = 1'b0;
        if (LOAD) begin
            nxt = load_val;
        end else if (EN) begin
            if (M) begin
                nxt      = inc;
                nxt_wrap = at_top;
            end else begin
                nxt      = dec;
                nxt_wrap = at_bot;
            end
        end
    end

    // Count register and wrap pulse, cleared asynchronously.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else begin
            Q    <= nxt;
            WRAP <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod: three configurations checked
// against a behavioural model plus directed literal expectations.
module tb_up_down_counter_mod;

    logic       CLK;
    logic       CLR;
    logic       en   [3];
    logic       m    [3];
    logic       load [3];
    logic [3:0] d    [3];
    logic [3:0] q    [3];
    logic       tc   [3];
    logic       wrap [3];

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    int mq [3];
    int mw [3];
    int mods [3] = '{16, 10, 10};
    int sats [3] = '{0, 0, 1};

    up_down_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u0 (
        .CLK(CLK), .CLR(CLR), .EN(en[0]), .M(m[0]), .LOAD(load[0]),
        .D(d[0]), .Q(q[0]), .TC(tc[0]), .WRAP(wrap[0]));
    up_down_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u1 (
        .CLK(CLK), .CLR(CLR), .EN(en[1]), .M(m[1]), .LOAD(load[1]),
        .D(d[1]), .Q(q[1]), .TC(tc[1]), .WRAP(wrap[1]));
    up_down_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u2 (
        .CLK(CLK), .CLR(CLR), .EN(en[2]), .M(m[2]), .LOAD(load[2]),
        .D(d[2]), .Q(q[2]), .TC(tc[2]), .WRAP(wrap[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Counter rules stated directly on integers.
    function automatic void step(input int cq, input int ld, input int dv,
                                 input int e, input int up, input int md,
                                 input int st, output int nq, output int nw);
        int top;
        top = md - 1;
        nq  = cq;
        nw  = 0;
        if (ld != 0) begin
            nq = (dv > top) ? top : dv;
        end else if (e != 0) begin
            if (up != 0) begin
                if (cq == top) begin
                    nq = (st != 0) ? cq : 0;
                    nw = 1;
                end else begin
                    nq = cq + 1;
                end
            end else begin
                if (cq == 0) begin
                    nq = (st != 0) ? cq : top;
                    nw = 1;
                end else begin
                    nq = cq - 1;
                end
            end
        end
    endfunction

    // Reference model advance.
    always @(posedge CLK or negedge CLR) begin
        for (int i = 0; i < 3; i++) begin
            if (!CLR) begin
                mq[i] = 0;
                mw[i] = 0;
            end else begin
                step(mq[i], int'(load[i]), int'(d[i]), int'(en[i]),
                     int'(m[i]), mods[i], sats[i], mq[i], mw[i]);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_q%0d", i), int'(q[i]), mq[i]);
                chk($sformatf("model_wrap%0d", i), int'(wrap[i]), mw[i]);
                chk($sformatf("model_tc%0d", i), int'(tc[i]),
                    m[i] ? int'(mq[i] == mods[i] - 1) : int'(mq[i] == 0));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    int exp2 [4] = '{1, 0, 9, 8};

    initial begin
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 0; m[i] = 0; load[i] = 0; d[i] = '0;
        end
        tick(2);
        chk_on = 1;
        chk("reset_q", int'(q[0]), 0);
        chk("reset_wrap", int'(wrap[0]), 0);

        // Test 1: free-running up count through the wrap.
        CLR = 1'b1; en[0] = 1; m[0] = 1;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            chk($sformatf("t1_q_%0d", k), int'(q[0]), k % 16);
            chk($sformatf("t1_wrap_%0d", k), int'(wrap[0]), int'(k == 16));
            chk($sformatf("t1_tc_%0d", k), int'(tc[0]), int'(k == 15));
        end
        en[0] = 0;

        // Test 2: modulus 10 down count across zero.
        load[1] = 1; d[1] = 4'd2;
        tick(1);
        chk("t2_load", int'(q[1]), 2);
        load[1] = 0; en[1] = 1; m[1] = 0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk($sformatf("t2_q_%0d", k), int'(q[1]), exp2[k]);
            chk($sformatf("t2_wrap_%0d", k), int'(wrap[1]), int'(k == 2));
        end
        en[1] = 0;

        // Test 3: saturating up count holds at 9.
        load[2] = 1; d[2] = 4'd8;
        tick(1);
        chk("t3_load", int'(q[2]), 8);
        load[2] = 0; en[2] = 1; m[2] = 1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk($sformatf("t3_q_%0d", k), int'(q[2]), 9);
            chk($sformatf("t3_wrap_%0d", k), int'(wrap[2]), int'(k > 0));
        end
        en[2] = 0;
        tick(1);
        chk("t3_wrap_off", int'(wrap[2]), 0);
        chk("t3_hold", int'(q[2]), 9);

        // Test 4: clamped load, then load beats a would-be wrap.
        load[1] = 1; d[1] = 4'd13; m[1] = 1;
        tick(1);
        chk("t4_clamp", int'(q[1]), 9);
        chk("t4_tc", int'(tc[1]), 1);
        d[1] = 4'd4; en[1] = 1;
        tick(1);
        chk("t4_loadwin", int'(q[1]), 4);
        chk("t4_wrap", int'(wrap[1]), 0);
        load[1] = 0; en[1] = 0;

        // Test 5: asynchronous clear mid-count.
        en[0] = 1; m[0] = 1;
        tick(5);
        chk("t5_pre", int'(q[0]), 6);
        #1 CLR = 1'b0;
        #1;
        chk("t5_async_q", int'(q[0]), 0);
        chk("t5_async_wrap", int'(wrap[0]), 0);
        tick(3);
        chk("t5_held", int'(q[0]), 0);
        CLR = 1'b1;
        tick(1);
        chk("t5_first", int'(q[0]), 1);
        en[0] = 0;

        // Test 6: direction flip between edges.
        m[1] = 1;
        #1;
        chk("t6_tc_up", int'(tc[1]), 0);
        m[1] = 0;
        #1;
        chk("t6_tc_dn", int'(tc[1]), 1);
        chk("t6_q_same", int'(q[1]), 0);
        en[1] = 1;
        tick(1);
        chk("t6_q", int'(q[1]), 9);
        chk("t6_wrap", int'(wrap[1]), 1);
        en[1] = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
